fft_frame_buffer: RTL and testbench
===================================

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 The module SHALL have one parameter: DATA_W, default 12, sample width in bits, which is the width of sample_in and x_0..x_7.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 sample_in  input  DATA_W  serial time-domain sample, two's complement.
REQ-006 sample_valid  input  1  sample_in is captured on a rising edge where this is high.
REQ-007 frame_ready  input  1  downstream FFT accepts the presented frame.
REQ-008 x_0..x_7  output  DATA_W each  parallel frame to the 8-point FFT; x_0 is the oldest sample, x_7 the newest.
REQ-009 frame_valid  output  1  x_0..x_7 hold an unaccepted frame.
REQ-010 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-011 The block SHALL keep an 8-entry capture shift register and a 3-bit fill counter, independent of the output registers (double buffering).
- Capture continues while a frame is presented.
REQ-012 On each edge with sample_valid=1, the block SHALL shift sample_in into the capture register and increment the fill counter modulo 8.
REQ-013 A frame SHALL complete on the edge where sample_valid=1 and the fill counter equals 7; the counter wraps to 0 on that edge.
REQ-014 On frame completion with frame_valid=0, or with frame_valid=1 and frame_ready=1, the block SHALL load x_0..x_7 from the capture register.
- The load includes the sample captured on that same edge as x_7.
- frame_valid SHALL be 1 after that edge.
REQ-015 Latency: frame_valid SHALL assert on the same edge that captures the 8th sample, with no extra cycle.
REQ-016 When frame_valid=1 and frame_ready=1 with no completion on that edge, frame_valid SHALL clear on that edge.
- x_0..x_7 SHALL hold their last values.
REQ-017 On frame completion with frame_valid=1 and frame_ready=0:
- the new frame SHALL be dropped;
- x_0..x_7 and frame_valid SHALL hold;
- overrun SHALL set to 1 and stay set until reset.
REQ-018 x_0..x_7 SHALL change only on a load edge and SHALL stay stable while frame_valid=1.
REQ-019 The output-side state machine SHALL have two states:
- EMPTY (frame_valid=0): EMPTY->FULL on completion.
- FULL (frame_valid=1): FULL->EMPTY on accept without completion; FULL->FULL on accept with completion.
REQ-020 frame_ready SHALL be ignored while frame_valid=0.
REQ-021 sample_valid=0 cycles SHALL leave the capture register and counter unchanged.
REQ-022 Sample values SHALL pass bit-exact, with no scaling or sign change.

Reset
REQ-023 While rst=1 on an edge, the block SHALL clear to zero:
- the capture register, fill counter and x_0..x_7;
- frame_valid and overrun.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first valid sample after reset SHALL become position 0 of the next frame.
REQ-025 rst SHALL take priority over sample_valid and frame_ready on the same edge.

Configuration
REQ-026 Macro FRAME_OVERLAP_EN SHALL select 50% frame overlap.
REQ-027 With FRAME_OVERLAP_EN defined:
- after the first frame, a frame SHALL complete every 4 further valid samples, i.e. on fill-counter values 7 and 3;
- each frame SHALL carry the latest 8 samples;
- the first frame still requires 8 samples after reset.
REQ-028 Without FRAME_OVERLAP_EN, frames SHALL be non-overlapping and complete every 8 valid samples (REQ-013).

Verification
REQ-029 Reset, then samples 1..8 on consecutive cycles with frame_ready=0 -> frame_valid=1 on the edge capturing 8; x_0=1 ... x_7=8; overrun=0.
REQ-030 Frame presented, frame_ready=1 for one cycle, no new samples -> frame_valid=0 next edge; x_0..x_7 still 1..8.
REQ-031 frame_ready=0 throughout, samples 1..16 -> x_0..x_7 remain 1..8; overrun=1 after the edge capturing 16.
REQ-032 Samples 1..8, then 9..16 with frame_ready=1 held through the edge capturing 16 -> frame_valid stays 1; x_0..x_7=9..16; overrun=0.
REQ-033 Samples 1..5, rst=1 for one cycle, then samples 0x7FF,0x800,1..6 -> frame x_0=0x7FF, x_1=0x800 (bit-exact), x_2..x_7=1..6.
REQ-034 With FRAME_OVERLAP_EN defined and frame_ready=1, samples 1..12 -> first frame 1..8; second frame 5..12 on the edge capturing 12.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// ============================================================================
// Module  : fft_frame_buffer
// Brief   : Serial-to-parallel 8-sample double-buffered frame builder for an
//           8-point FFT. Define FRAME_OVERLAP_EN for 50% frame overlap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_buffer #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] x_0,
  output logic [DATA_W-1:0] x_1,
  output logic [DATA_W-1:0] x_2,
  output logic [DATA_W-1:0] x_3,
  output logic [DATA_W-1:0] x_4,
  output logic [DATA_W-1:0] x_5,
  output logic [DATA_W-1:0] x_6,
  output logic [DATA_W-1:0] x_7,
  output logic              frame_valid,
  output logic              overrun
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_cap      [8];
  logic [DATA_W-1:0] w_cap_next [8];
  logic [DATA_W-1:0] r_x        [8];
  logic [2:0]        r_cnt;
  logic              r_frame_valid;
  logic              r_overrun;
  logic              w_complete;
  logic              w_load;

  // Index 0 holds the oldest sample; the incoming sample lands at index 7.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_cap_next[i] = r_cap[i+1];
    end
    w_cap_next[7] = sample_in;
  end

`ifdef FRAME_OVERLAP_EN
  // Set once the first full frame after reset has been seen, enabling the
  // mid-frame completion point.
  logic r_primed;
  assign w_complete = sample_valid &&
                      ((r_cnt == 3'd7) || (r_primed && (r_cnt == 3'd3)));
`else
  assign w_complete = sample_valid && (r_cnt == 3'd7);
`endif

  assign w_load = w_complete && ((r_state == S_EMPTY) || frame_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_cnt         <= 3'd0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_cap[i] <= '0;
        r_x[i]   <= '0;
      end
`ifdef FRAME_OVERLAP_EN
      r_primed      <= 1'b0;
`endif
    end else begin
      if (sample_valid) begin
        r_cap <= w_cap_next;
        r_cnt <= r_cnt + 3'd1;
`ifdef FRAME_OVERLAP_EN
        if (r_cnt == 3'd7) begin
          r_primed <= 1'b1;
        end
`endif
      end

      if (w_load) begin
        r_x <= w_cap_next;
      end

      case (r_state)
        S_EMPTY: begin
          if (w_complete) begin
            r_state       <= S_FULL;
            r_frame_valid <= 1'b1;
          end
        end
        S_FULL: begin
          // A frame completing while the previous one is unaccepted is lost.
          if (w_complete && !frame_ready) begin
            r_overrun <= 1'b1;
          end else if (frame_ready && !w_complete) begin
            r_state       <= S_EMPTY;
            r_frame_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_EMPTY;
          r_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  assign x_0         = r_x[0];
  assign x_1         = r_x[1];
  assign x_2         = r_x[2];
  assign x_3         = r_x[3];
  assign x_4         = r_x[4];
  assign x_5         = r_x[5];
  assign x_6         = r_x[6];
  assign x_7         = r_x[7];
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
// ============================================================================
// Module  : tb_fft_frame_buffer
// Brief   : Directed self-checking bench for fft_frame_buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_buffer;

  localparam int DATA_W = 12;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7;
  logic              frame_valid;
  logic              overrun;
  logic [DATA_W-1:0] w_x [8];

  int n_tests = 0;
  int n_fail  = 0;

  fft_frame_buffer #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_ready  (frame_ready),
    .x_0          (x_0),
    .x_1          (x_1),
    .x_2          (x_2),
    .x_3          (x_3),
    .x_4          (x_4),
    .x_5          (x_5),
    .x_6          (x_6),
    .x_7          (x_7),
    .frame_valid  (frame_valid),
    .overrun      (overrun)
  );

  assign w_x[0] = x_0;
  assign w_x[1] = x_1;
  assign w_x[2] = x_2;
  assign w_x[3] = x_3;
  assign w_x[4] = x_4;
  assign w_x[5] = x_5;
  assign w_x[6] = x_6;
  assign w_x[7] = x_7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    sample_in    = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sample_in    = 12'h5A5;
    sample_valid = 1'b1;
    frame_ready  = 1'b1;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frame_valid: got %b expected 0", frame_valid);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_x%0d: got %h expected 000", i, w_x[i]);
      end
    end
  endtask

  task automatic test_ready_ignored_when_empty();
    frame_ready = 1'b1;
    tick();
    tick();
    frame_ready = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_when_empty: frame_valid got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int s = 1; s <= 7; s++) send(DATA_W'(s));
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_after7: frame_valid got %b expected 0", frame_valid);
    end
    send(DATA_W'(8));
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_latency: frame_valid got %b expected 1", frame_valid);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_overrun: got %b expected 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 1));
      end
    end
  endtask

  // Continues from test_fill: frame 1..8 presented.
  task automatic test_accept();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_clear: frame_valid got %b expected 0", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL accept_hold_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 1));
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int s = 1; s <= 15; s++) send(DATA_W'(s));
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: got %b expected 0", overrun);
    end
    send(DATA_W'(16));
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_valid_hold: got %b expected 1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL overrun_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 1));
      end
    end
    // Sticky: accepting the frame must not clear the flag.
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int s = 1; s <= 15; s++) send(DATA_W'(s));
    frame_ready = 1'b1;
    send(DATA_W'(16));
    frame_ready = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_valid: got %b expected 1", frame_valid);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 9)) begin
        n_fail++;
        $display("FAIL b2b_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 9));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [DATA_W-1:0] exp [8];
    exp[0] = 12'h7FF;
    exp[1] = 12'h800;
    for (int i = 2; i < 8; i++) exp[i] = DATA_W'(i - 1);
    do_reset();
    for (int s = 1; s <= 5; s++) send(DATA_W'(s));
    do_reset();
    send(12'h7FF);
    send(12'h800);
    tick();  // idle cycle must not disturb the capture
    for (int s = 1; s <= 5; s++) send(DATA_W'(s));
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after7: frame_valid got %b expected 0", frame_valid);
    end
    send(DATA_W'(6));
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b expected 1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL midrst_x%0d: got %h expected %h", i, w_x[i], exp[i]);
      end
    end
  endtask

`ifdef FRAME_OVERLAP_EN
  task automatic test_overlap();
    do_reset();
    frame_ready = 1'b1;
    for (int s = 1; s <= 8; s++) send(DATA_W'(s));
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 1)) begin
        n_fail++;
        $display("FAIL ovl_first_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 1));
      end
    end
    for (int s = 9; s <= 11; s++) send(DATA_W'(s));
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_gap_valid: got %b expected 0", frame_valid);
    end
    send(DATA_W'(12));
    frame_ready = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovl_second_valid: got %b expected 1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (w_x[i] !== DATA_W'(i + 5)) begin
        n_fail++;
        $display("FAIL ovl_second_x%0d: got %h expected %h", i, w_x[i], DATA_W'(i + 5));
      end
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    tick();
    test_reset();
    test_ready_ignored_when_empty();
    test_fill();
    test_accept();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
`ifdef FRAME_OVERLAP_EN
    test_overlap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
